pwm_sequencer: RTL and testbench

Controller that sequences the PWM generator through a programmable table of duty-cycle steps. It holds each step for a programmed number of PWM periods and issues start/stop to the PWM control unit. It pushes new duty values to the PWM datapath only at period boundaries, so no glitched periods occur. It sits between the register/host interface and the PWM core (control unit plus counter/compare datapath).

---
 rtl/pwm_sequencer_if.sv | 38 +++
 rtl/pwm_sequencer.sv | 146 ++++++++++++++
 tb/tb_pwm_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sequencer_if.sv
// pwm_sequencer host/core signal bundle.
// master drives table/control inputs, slave is the sequencer.
interface pwm_sequencer_if #(
  parameter int IDXW  = 3,
  parameter int WIDTH = 8,
  parameter int REPW  = 8
);
  logic             wr_en;
  logic [IDXW-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_duty;
  logic [REPW-1:0]  wr_reps;
  logic [IDXW-1:0]  seq_len;
  logic             loop;
  logic             go;
  logic             halt;
  logic             period_done;
  logic             pwm_start;
  logic             pwm_stop;
  logic [WIDTH-1:0] duty;
  logic             duty_load;
  logic             busy;
  logic             done;
  logic [IDXW-1:0]  cur_idx;

  modport master (
    output wr_en, wr_addr, wr_duty, wr_reps,
    output seq_len, loop, go, halt, period_done,
    input  pwm_start, pwm_stop, duty, duty_load,
    input  busy, done, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_duty, wr_reps,
    input  seq_len, loop, go, halt, period_done,
    output pwm_start, pwm_stop, duty, duty_load,
    output busy, done, cur_idx
  );
endinterface

// File: rtl/pwm_sequencer.sv
// Steps the PWM core through a table of duty values,
// updating duty only on period boundaries.
module pwm_sequencer #(
  parameter int IDXW  = 3,
  parameter int WIDTH = 8,
  parameter int REPW  = 8
) (
  input logic            clk,
  input logic            reset,
  pwm_sequencer_if.slave bus
);
  localparam int DEPTH = 2 ** IDXW;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [WIDTH-1:0] tduty_q [DEPTH];
  logic [REPW-1:0]  treps_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [REPW-1:0]  rep_q, rep_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             busy_q;

  logic             wr_ok;
  logic [WIDTH-1:0] duty0;
  logic [IDXW-1:0]  idx_nx;

  assign wr_ok  = bus.wr_en && (state_q == IDLE);
  // a write to entry 0 on the go edge must reach the launch duty
  assign duty0  = (wr_ok && bus.wr_addr == '0) ?
                  bus.wr_duty : tduty_q[0];
  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rep_d   = rep_q;
    loop_d  = loop_q;
    duty_d  = duty_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    load_d  = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        if (bus.go) begin
          last_d  = bus.seq_len;
          loop_d  = bus.loop;
          idx_d   = '0;
          rep_d   = '0;
          duty_d  = duty0;
          load_d  = 1'b1;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      state_q == LAUNCH: begin
        state_d = bus.halt ? STOP : RUN;
      end
      state_q == RUN: begin
        if (bus.halt) begin
          state_d = STOP;
        end else if (bus.period_done) begin
          if (rep_q != treps_q[idx_q]) begin
            rep_d = rep_q + 1'b1;
          end else if (idx_q != last_q) begin
            idx_d  = idx_nx;
            rep_d  = '0;
            duty_d = tduty_q[idx_nx];
            load_d = 1'b1;
          end else if (loop_q) begin
            idx_d  = '0;
            rep_d  = '0;
            duty_d = tduty_q[0];
            load_d = 1'b1;
          end else begin
            state_d = STOP;
            stop_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      state_q == STOP: begin
        // natural exit enters with stop already out;
        // a halt exit spends one cycle raising it
        if (stop_q) state_d = IDLE;
        else        stop_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      loop_q  <= 1'b0;
      duty_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tduty_q[i] <= '0;
        treps_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      loop_q  <= loop_d;
      duty_q  <= duty_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      load_q  <= load_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      if (wr_ok) begin
        tduty_q[bus.wr_addr] <= bus.wr_duty;
        treps_q[bus.wr_addr] <= bus.wr_reps;
      end
    end
  end

  assign bus.pwm_start = start_q;
  assign bus.pwm_stop  = stop_q;
  assign bus.duty      = duty_q;
  assign bus.duty_load = load_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_idx   = idx_q;
endmodule

// File: tb/tb_pwm_sequencer.sv
// Randomized bench for pwm_sequencer against a
// period-count reference model of the step table.
module tb_pwm_sequencer;
  localparam int IDXW  = 3;
  localparam int WIDTH = 8;
  localparam int REPW  = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pwm_sequencer_if #(
    .IDXW(IDXW), .WIDTH(WIDTH), .REPW(REPW)
  ) bus ();

  pwm_sequencer #(
    .IDXW(IDXW), .WIDTH(WIDTH), .REPW(REPW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int m_duty [DEPTH];
  int m_reps [DEPTH];

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int st,
                      input int sp, input int ld,
                      input int dn, input int by,
                      input int du, input int ci);
    chk({tag, ".start"}, int'(bus.pwm_start), st);
    chk({tag, ".stop"},  int'(bus.pwm_stop), sp);
    chk({tag, ".load"},  int'(bus.duty_load), ld);
    chk({tag, ".done"},  int'(bus.done), dn);
    chk({tag, ".busy"},  int'(bus.busy), by);
    chk({tag, ".duty"},  int'(bus.duty), du);
    chk({tag, ".idx"},   int'(bus.cur_idx), ci);
  endtask

  task automatic wr(input int a, input int d, input int r);
    bus.wr_en   = 1'b1;
    bus.wr_addr = IDXW'(a);
    bus.wr_duty = WIDTH'(d);
    bus.wr_reps = REPW'(r);
    tick();
    bus.wr_en = 1'b0;
    m_duty[a] = d;
    m_reps[a] = r;
  endtask

  function automatic int seq_total(input int last);
    int t = 0;
    for (int i = 0; i <= last; i++) t += m_reps[i] + 1;
    return t;
  endfunction

  // Event caused by the k-th period of a run:
  // 0 none, 1 load entry e, 2 natural end.
  function automatic void exp_event(
    input int k, input int last, input bit lp,
    output int kind, output int e);
    int total;
    int cum;
    int kk;
    total = seq_total(last);
    cum   = 0;
    kk    = lp ? ((k - 1) % total) + 1 : k;
    kind  = 0;
    e     = 0;
    for (int i = 0; i <= last; i++) begin
      cum += m_reps[i] + 1;
      if (kk == cum) begin
        if (i < last)  begin kind = 1; e = i + 1; end
        else if (lp)   begin kind = 1; e = 0; end
        else           kind = 2;
      end
    end
  endfunction

  // halt_k>0: halt raised together with period k.
  // Loop runs halt (without a period) after npd periods.
  task automatic run(input int last, input bit lp,
                     input int npd, input int halt_k,
                     input bit wr_busy);
    int k;
    int kind;
    int e;
    int ed;
    int ec;
    bit fin;
    bus.seq_len = IDXW'(last);
    bus.loop    = lp;
    bus.go      = 1'b1;
    tick();
    bus.go    = 1'b0;
    bus.wr_en = 1'b0;
    ed = m_duty[0];
    ec = 0;
    outs("launch", 1, 0, 1, 0, 1, ed, ec);
    tick();
    outs("run0", 0, 0, 0, 0, 1, ed, ec);
    k   = 0;
    fin = 1'b0;
    while (!fin && k < 4000) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        outs("gap", 0, 0, 0, 0, 1, ed, ec);
      end
      k++;
      if (halt_k == k || (lp && k > npd)) begin
        bus.halt        = 1'b1;
        bus.period_done = (halt_k == k);
        tick();
        bus.halt        = 1'b0;
        bus.period_done = 1'b0;
        outs("halt1", 0, 0, 0, 0, 1, ed, ec);
        tick();
        outs("halt2", 0, 1, 0, 0, 1, ed, ec);
        tick();
        outs("halt3", 0, 0, 0, 0, 0, ed, ec);
        fin = 1'b1;
      end else begin
        bus.period_done = 1'b1;
        if (wr_busy) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = '0;
          bus.wr_duty = 8'd99;
          bus.wr_reps = 8'd7;
        end
        tick();
        bus.period_done = 1'b0;
        bus.wr_en       = 1'b0;
        exp_event(k, last, lp, kind, e);
        if (kind == 1) begin
          ed = m_duty[e];
          ec = e;
          outs("step", 0, 0, 1, 0, 1, ed, ec);
        end else if (kind == 2) begin
          outs("end1", 0, 1, 0, 1, 1, ed, ec);
          tick();
          outs("end2", 0, 0, 0, 0, 0, ed, ec);
          fin = 1'b1;
        end else begin
          outs("hold", 0, 0, 0, 0, 1, ed, ec);
        end
      end
    end
    chk("run_finished", int'(fin), 1);
  endtask

  initial begin
    int last;
    int lp;
    int npd;
    int hk;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_duty     = '0;
    bus.wr_reps     = '0;
    bus.seq_len     = '0;
    bus.loop        = 1'b0;
    bus.go          = 1'b0;
    bus.halt        = 1'b0;
    bus.period_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_duty[i] = 0;
      m_reps[i] = 0;
    end
    #3;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    #9 reset = 1'b0;
    tick();
    outs("idle", 0, 0, 0, 0, 0, 0, 0);

    wr(0, 10, 0);
    wr(1, 50, 2);
    run(1, 0, 0, 0, 0);
    run(1, 1, 8, 0, 0);
    run(1, 0, 0, 1, 0);
    run(1, 0, 0, 0, 1);
    run(1, 0, 0, 0, 0);

    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_duty = 8'd77;
    bus.wr_reps = 8'd1;
    m_duty[0] = 77;
    m_reps[0] = 1;
    run(1, 0, 0, 0, 0);

    wr(0, 200, 255);
    run(0, 0, 0, 0, 0);

    repeat (12) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)));
      last = int'($urandom_range(0, DEPTH - 1));
      lp   = int'($urandom_range(0, 1));
      npd  = int'($urandom_range(1, 20));
      hk   = 0;
      if ($urandom_range(0, 3) == 0) begin
        hk = int'($urandom_range(1, seq_total(last)));
        if (lp != 0 && hk > npd) hk = npd;
      end
      run(last, lp[0], npd, hk, $urandom_range(0, 1) == 1);
    end

    wr(0, 10, 0);
    wr(1, 50, 2);
    bus.seq_len = 3'd1;
    bus.loop    = 1'b0;
    bus.go      = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    bus.period_done = 1'b1;
    tick();
    bus.period_done = 1'b0;
    outs("pre_rst", 0, 0, 1, 0, 1, 50, 1);
    #2 reset = 1'b1;
    #1;
    outs("async_rst", 0, 0, 0, 0, 0, 0, 0);
    tick();
    outs("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_duty[i] = 0;
      m_reps[i] = 0;
    end
    tick();
    run(1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
